vga_write_arbiter: RTL
======================

// Module: vga_write_arbiter
// PURPOSE
//  Sits between the pixel producers (title screen, game renderer) and the VGA adapter write port.
//  Grants the title source until it reports completion, optionally blanks the playfield, then grants the game source.
//  Output is a single registered pixel-write stream; the VGA adapter never stalls.
// PARAMETERS
//  XSCREEN      640        screen width; writes with x >= XSCREEN are suppressed
//  YSCREEN      480        screen height; writes with y >= YSCREEN are suppressed
//  CLEAR_X0     0          clear rectangle left edge
//  CLEAR_Y0     0          clear rectangle top edge
//  CLEAR_W      640        clear rectangle width, 1..XSCREEN
//  CLEAR_H      480        clear rectangle height, 1..YSCREEN
//  CLEAR_COLOR  9'h000     colour written during clear
// PORTS
//  Clock           in   1   system clock
//  Resetn          in   1   synchronous, active-low reset
//  title_x         in   10  title pixel x
//  title_y         in   9   title pixel y
//  title_color     in   9   title pixel colour, RGB 3:3:3
//  title_write     in   1   title pixel strobe; no backpressure
//  title_complete  in   1   level; title has finished erasing itself
//  game_x          in   10  game pixel x
//  game_y          in   9   game pixel y
//  game_color      in   9   game pixel colour
//  game_write      in   1   game valid
//  game_ready      out  1   game ready; transfer = game_write & game_ready
//  VGA_x           out  10  to adapter
//  VGA_y           out  9   to adapter
//  VGA_color       out  9   to adapter
//  VGA_write       out  1   to adapter
//  mode            out  2   0=TITLE 1=CLEAR 2=GAME
//  drop_count      out  8   saturating count of title writes ignored outside TITLE
// BEHAVIOUR
//  Reset (Resetn=0 at a Clock edge): state TITLE; VGA_x/VGA_y/VGA_color/VGA_write=0; drop_count=0; clear counters=0.
//   Any reset mid-CLEAR or mid-GAME aborts immediately and returns to TITLE.
//  game_ready: combinational, 1 only in GAME; 0 in TITLE, 0 in CLEAR, 0 during reset.
//  Latency: accepted write at edge N appears on VGA_* after edge N (one register stage). VGA_write=1 for exactly one cycle per write.
//  Bounds filter: x >= XSCREEN or y >= YSCREEN -> VGA_write=0 that cycle. Coordinates still update VGA_x/VGA_y. Not counted as a drop.
//  TITLE: forwards title_* when title_write=1; game input is ignored.
//   When title_complete=1, a title write in that same cycle is still forwarded.
//   Next state on title_complete=1 is CLEAR (macro on) or GAME (macro off).
//  CLEAR: one pixel per cycle at (CLEAR_X0+cx, CLEAR_Y0+cy), colour CLEAR_COLOR, raster order (cx fastest).
//   Takes exactly CLEAR_W*CLEAR_H cycles; the cycle after the last pixel state=GAME.
//   Counters reset to 0 on entry.
//  GAME: forwards game_* on a transfer; VGA_write=0 otherwise. Terminal until reset; title_complete ignored.
//  Drops: title_write=1 in CLEAR or GAME increments drop_count, saturating at 255.
//  Bits of x/y beyond screen range are never truncated silently; the filter decides.
// CONFIGURATION
//  CLEAR_ON_SWITCH_EN defined: TITLE -> CLEAR -> GAME as above.
//  Not defined: CLEAR state and clear counters are absent; TITLE -> GAME on the cycle after title_complete=1; mode never reports 1.
// STRUCTURE
//  Package laner_vga_pkg: XSCREEN/YSCREEN, mode encoding (MODE_TITLE/MODE_CLEAR/MODE_GAME), colour constants (BLACK, YELLOW).
//  Sub-module rect_clear_scanner: start pulse, CLEAR_W/CLEAR_H params -> x/y/valid/last. Instantiated only under CLEAR_ON_SWITCH_EN.
//  Top keeps the FSM, output register, bounds filter and drop counter.
// TESTING
//  1 Reset, title_write with (100,150,9'h1F8) -> next cycle VGA_write=1 at x=100 y=150 colour 1F8; game_ready=0.
//  2 Title write at x=640 y=10 -> VGA_write=0; at x=639 y=479 -> VGA_write=1.
//  3 Macro on, CLEAR_W=4, CLEAR_H=2, pulse title_complete -> 8 black writes (0,0)..(3,1) in raster order, then mode=2, game_ready=1.
//  4 GAME, game_write held 3 cycles with distinct pixels -> 3 consecutive VGA writes, same order, 1-cycle latency.
//  5 title_write held 300 cycles in GAME -> drop_count=255, no VGA writes.
//  6 Resetn=0 mid-CLEAR -> mode=0, VGA_write=0, drop_count=0 next cycle. Macro off -> title_complete goes straight to mode=2.

Source files
------------

// File: rtl/laner_vga_pkg.sv
// Shared constants for the VGA write path: screen geometry, arbiter mode encoding, colours.
// Combinational only; no latency.
// No flow control; constants and a bounds-check helper only.
package laner_vga_pkg;

    localparam int XSCREEN = 640;
    localparam int YSCREEN = 480;

    // Arbiter mode, also driven out on the mode port.
    typedef enum logic [1:0] {
        MODE_TITLE = 2'd0,
        MODE_CLEAR = 2'd1,
        MODE_GAME  = 2'd2
    } mode_t;

    // RGB 3:3:3 colours.
    localparam logic [8:0] BLACK  = 9'h000;
    localparam logic [8:0] YELLOW = 9'h1F8;

    // Coordinates arrive one bit wider than the VGA port, so that an
    // off-screen rectangle is rejected here and never wraps onto the screen.
    function automatic logic on_screen(input logic [10:0] x, input logic [9:0] y,
                                       input int xs, input int ys);
        return (x < 11'(xs)) && (y < 10'(ys));
    endfunction

endpackage

// File: rtl/rect_clear_scanner.sv
// Raster scanner for a CLEAR_W x CLEAR_H rectangle: one coordinate per cycle, x fastest.
// Latency: first pixel valid the cycle after start; runs exactly CLEAR_W*CLEAR_H cycles.
// No backpressure: the consumer must take a pixel every cycle valid is high.
//
// Ports: Clock, Resetn (sync, active-low), start (pulse, restarts from the origin),
//        x/y (absolute coordinates, one bit wider than the screen), valid, last.
module rect_clear_scanner #(
    parameter int CLEAR_X0 = 0,
    parameter int CLEAR_Y0 = 0,
    parameter int CLEAR_W  = 640,
    parameter int CLEAR_H  = 480
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        valid,
    output logic        last
);

    localparam logic [9:0] CX_LAST = 10'(CLEAR_W - 1);
    localparam logic [8:0] CY_LAST = 9'(CLEAR_H - 1);

    logic       busy;
    logic [9:0] cx;
    logic [8:0] cy;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            busy <= 1'b0;
            cx   <= '0;
            cy   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cx   <= '0;
            cy   <= '0;
        end else if (busy) begin
            if (cx == CX_LAST) begin
                cx <= '0;
                if (cy == CY_LAST) begin
                    cy   <= '0;
                    busy <= 1'b0;
                end else begin
                    cy <= cy + 9'd1;
                end
            end else begin
                cx <= cx + 10'd1;
            end
        end
    end

    assign x     = 11'(CLEAR_X0) + {1'b0, cx};
    assign y     = 10'(CLEAR_Y0) + {1'b0, cy};
    assign valid = busy;
    assign last  = busy && (cx == CX_LAST) && (cy == CY_LAST);

endmodule

// File: rtl/vga_write_arbiter.sv
// Arbitrates title and game pixel producers onto the VGA adapter write port (title, [clear], game).
// Latency: one register stage; a write accepted at edge N is on VGA_* after edge N.
// Backpressure: title has none (writes outside TITLE are dropped and counted); game is valid/ready, ready only in GAME.
//
// Optional feature macro: CLEAR_ON_SWITCH_EN -- when defined, the playfield rectangle is
// blanked (CLEAR mode) between TITLE and GAME; otherwise TITLE goes straight to GAME.
// Ports: Clock, Resetn (sync, active-low); title_* pixel strobe + title_complete level;
//        game_* valid/ready pixel stream; VGA_* registered write to the adapter;
//        mode (0 title, 1 clear, 2 game); drop_count (saturating title drops).
module vga_write_arbiter
    import laner_vga_pkg::*;
#(
    parameter int         XSCREEN     = laner_vga_pkg::XSCREEN,
    parameter int         YSCREEN     = laner_vga_pkg::YSCREEN,
    parameter int         CLEAR_X0    = 0,
    parameter int         CLEAR_Y0    = 0,
    parameter int         CLEAR_W     = 640,
    parameter int         CLEAR_H     = 480,
    parameter logic [8:0] CLEAR_COLOR = BLACK
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [9:0]  title_x,
    input  logic [8:0]  title_y,
    input  logic [8:0]  title_color,
    input  logic        title_write,
    input  logic        title_complete,
    input  logic [9:0]  game_x,
    input  logic [8:0]  game_y,
    input  logic [8:0]  game_color,
    input  logic        game_write,
    output logic        game_ready,
    output logic [9:0]  VGA_x,
    output logic [8:0]  VGA_y,
    output logic [8:0]  VGA_color,
    output logic        VGA_write,
    output logic [1:0]  mode,
    output logic [7:0]  drop_count
);

    // Geometry sanity: the clear rectangle must be non-empty and fit the screen.
    if (CLEAR_W < 1 || CLEAR_W > XSCREEN || CLEAR_H < 1 || CLEAR_H > YSCREEN ||
        CLEAR_X0 < 0 || CLEAR_Y0 < 0) begin : g_bad_geometry
        $error("vga_write_arbiter: clear rectangle geometry out of range");
    end

    mode_t state, state_nxt;

    // Selected source for this cycle, widened so out-of-range bits reach the filter.
    logic        src_load;
    logic [10:0] src_x;
    logic [9:0]  src_y;
    logic [8:0]  src_color;

`ifdef CLEAR_ON_SWITCH_EN
    logic        clr_start;
    logic [10:0] clr_x;
    logic [9:0]  clr_y;
    logic        clr_valid;
    logic        clr_last;

    // Counters restart on every entry into CLEAR, including after an aborted clear.
    assign clr_start = (state == MODE_TITLE) && title_complete;

    rect_clear_scanner #(
        .CLEAR_X0 (CLEAR_X0),
        .CLEAR_Y0 (CLEAR_Y0),
        .CLEAR_W  (CLEAR_W),
        .CLEAR_H  (CLEAR_H)
    ) u_scanner (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (clr_start),
        .x      (clr_x),
        .y      (clr_y),
        .valid  (clr_valid),
        .last   (clr_last)
    );
`endif

    // Next-state and source selection.
    always_comb begin
        state_nxt = state;
        src_load  = 1'b0;
        src_x     = '0;
        src_y     = '0;
        src_color = '0;
        case (state)
            MODE_TITLE: begin
                // A title pixel in the same cycle as title_complete is still forwarded.
                if (title_write) begin
                    src_load  = 1'b1;
                    src_x     = {1'b0, title_x};
                    src_y     = {1'b0, title_y};
                    src_color = title_color;
                end
                if (title_complete) begin
`ifdef CLEAR_ON_SWITCH_EN
                    state_nxt = MODE_CLEAR;
`else
                    state_nxt = MODE_GAME;
`endif
                end
            end
`ifdef CLEAR_ON_SWITCH_EN
            MODE_CLEAR: begin
                if (clr_valid) begin
                    src_load  = 1'b1;
                    src_x     = clr_x;
                    src_y     = clr_y;
                    src_color = CLEAR_COLOR;
                end
                if (clr_last) begin
                    state_nxt = MODE_GAME;
                end
            end
`endif
            MODE_GAME: begin
                // GAME is terminal until reset; title_complete is ignored here.
                if (game_write) begin
                    src_load  = 1'b1;
                    src_x     = {1'b0, game_x};
                    src_y     = {1'b0, game_y};
                    src_color = game_color;
                end
            end
            default: begin
                state_nxt = MODE_TITLE;
            end
        endcase
    end

    // Output register, state register and drop counter.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state      <= MODE_TITLE;
            VGA_x      <= '0;
            VGA_y      <= '0;
            VGA_color  <= '0;
            VGA_write  <= 1'b0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            // Off-screen pixels still move the coordinates but never strobe the adapter.
            VGA_write <= src_load && on_screen(src_x, src_y, XSCREEN, YSCREEN);
            if (src_load) begin
                VGA_x     <= src_x[9:0];
                VGA_y     <= src_y[8:0];
                VGA_color <= src_color;
            end
            if (title_write && (state != MODE_TITLE) && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Gated by Resetn so the producer never sees ready while reset is being applied.
    assign game_ready = Resetn && (state == MODE_GAME);
    assign mode       = state;

endmodule
